// File: rtl/gf180mcu_osu_sc_gp12t3v3__syncfilt_1.sv
// gf180mcu_osu_sc_gp12t3v3__syncfilt_1: synchronizer + glitch filter + edge pulses + saturating transition counter
module gf180mcu_osu_sc_gp12t3v3__syncfilt_1 #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT        = 3,
    parameter int   CW          = 8,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic          CLK,
    input  logic          RN,
    input  logic          A,
    input  logic          EN,
    input  logic          CLR,
    output logic          Y,
    output logic          RISE,
    output logic          FALL,
    output logic [CW-1:0] CNT,
    output logic          OVF
);
    localparam int FW = $clog2(FILT + 1);

    typedef enum logic {STABLE, PENDING} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic                   y_q, y_d, rise_q, rise_d, fall_q, fall_d, ovf_q, ovf_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   s, acc;

    assign s    = sync_q[SYNC_STAGES-1];
    assign Y    = y_q;
    assign RISE = rise_q;
    assign FALL = fall_q;
    assign CNT  = cnt_q;
    assign OVF  = ovf_q;

    // Next state: shift the sync chain, qualify the new level, then update the counter
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], A};
        state_d = state_q;
        fcnt_d  = fcnt_q;
        acc     = 1'b0;
        if (state_q == STABLE) begin
            fcnt_d = '0;
            if (s != y_q) begin
                if (FILT == 1) begin
                    acc = 1'b1;
                end else begin
                    fcnt_d  = FW'(1);
                    state_d = PENDING;
                end
            end
        end else if (s == y_q) begin
            fcnt_d  = '0;
            state_d = STABLE;
        end else if (fcnt_q + FW'(1) == FW'(FILT)) begin
            acc     = 1'b1;
            fcnt_d  = '0;
            state_d = STABLE;
        end else begin
            fcnt_d = fcnt_q + FW'(1);
        end
        y_d    = acc ? s : y_q;
        rise_d = acc & s;
        fall_d = acc & ~s;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (CLR) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (acc && EN) begin
            if (cnt_q == {CW{1'b1}}) ovf_d = 1'b1;
            else cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers with immediate asynchronous reset
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            state_q <= STABLE;
            fcnt_q  <= '0;
            y_q     <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            y_q     <= y_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__syncfilt_1.sv
// tb_gf180mcu_osu_sc_gp12t3v3__syncfilt_1: directed + random checks against a run-length reference model
module tb_gf180mcu_osu_sc_gp12t3v3__syncfilt_1;
    localparam int SS = 2;
    localparam int FL = 3;

    logic       clk = 1'b0, rn = 1'b0, a = 1'b0, en = 1'b0, clr = 1'b0;
    logic       y, rise, fall, ovf, y2, rise2, fall2, ovf2;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    int         total = 0, bad = 0;
    bit         sh[SS];
    bit         my, mr, mf, mo, mo2;
    int         run, mc, mc2;

    always #5 clk = ~clk;

    gf180mcu_osu_sc_gp12t3v3__syncfilt_1 u1 (
        .CLK(clk), .RN(rn), .A(a), .EN(en), .CLR(clr),
        .Y(y), .RISE(rise), .FALL(fall), .CNT(cnt), .OVF(ovf)
    );

    gf180mcu_osu_sc_gp12t3v3__syncfilt_1 #(.CW(2)) u2 (
        .CLK(clk), .RN(rn), .A(a), .EN(en), .CLR(clr),
        .Y(y2), .RISE(rise2), .FALL(fall2), .CNT(cnt2), .OVF(ovf2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (sh[i]) sh[i] = 1'b0;
        my = 0; mr = 0; mf = 0; mo = 0; mo2 = 0;
        run = 0; mc = 0; mc2 = 0;
    endtask

    // New level accepted once FILT consecutive synchronized samples disagree with Y
    task automatic model_step();
        bit s;
        bit acc;
        if (!rn) begin
            model_reset();
            return;
        end
        s = sh[SS-1];
        for (int i = SS - 1; i > 0; i--) sh[i] = sh[i-1];
        sh[0] = a;
        acc = 0;
        if (s != my) begin
            run++;
            if (run == FL) begin
                acc = 1;
                my = s;
                run = 0;
            end
        end else run = 0;
        mr = acc && my;
        mf = acc && !my;
        if (clr) begin
            mc = 0; mo = 0; mc2 = 0; mo2 = 0;
        end else if (acc && en) begin
            if (mc == 255) mo = 1; else mc++;
            if (mc2 == 3) mo2 = 1; else mc2++;
        end
    endtask

    task automatic check_all();
        chk("y", y, my);
        chk("rise", rise, mr);
        chk("fall", fall, mf);
        chk("cnt", cnt, mc);
        chk("ovf", ovf, mo);
        chk("y2", y2, my);
        chk("rise2", rise2, mr);
        chk("fall2", fall2, mf);
        chk("cnt2", cnt2, mc2);
        chk("ovf2", ovf2, mo2);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rn = 1'b0;
        model_reset();
        #1;
        check_all();
        tick();
        tick();
        rn = 1'b1;
    endtask

    initial begin
        int pulses;
        // reset and latency
        do_reset();
        en = 1'b1;
        repeat (9) tick();
        a = 1'b1;
        repeat (4) begin
            tick();
            chk("lat_y_low", y, 0);
        end
        tick();
        chk("lat_y", y, 1);
        chk("lat_rise", rise, 1);
        chk("lat_cnt", cnt, 1);
        tick();
        chk("rise_one_cycle", rise, 0);
        // glitch rejection then a just-long-enough pulse
        a = 1'b0;
        do_reset();
        a = 1'b1;
        tick();
        tick();
        a = 1'b0;
        repeat (8) begin
            tick();
            chk("glitch_y", y, 0);
            chk("glitch_rise", rise, 0);
        end
        chk("glitch_cnt", cnt, 0);
        a = 1'b1;
        repeat (3) tick();
        a = 1'b0;
        repeat (10) tick();
        chk("min_pulse_cnt", cnt, 2);
        chk("min_pulse_y", y, 0);
        // saturation on the narrow counter
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            a = ~a;
            repeat (7) tick();
            if (k == 3) chk("sat3_ovf2", ovf2, 0);
        end
        chk("sat_cnt2", cnt2, 3);
        chk("sat_ovf2", ovf2, 1);
        chk("sat_cnt8", cnt, 5);
        // clear wins over a same-edge accept
        a = 1'b0;
        do_reset();
        a = 1'b1;
        repeat (7) tick();
        a = 1'b0;
        repeat (7) tick();
        chk("pre_clr_cnt", cnt, 2);
        a = 1'b1;
        repeat (4) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cnt", cnt, 0);
        chk("clr_ovf", ovf, 0);
        chk("clr_y", y, 1);
        chk("clr_rise", rise, 1);
        // enable gating
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a = ~a;
            pulses = 0;
            repeat (7) begin
                tick();
                pulses += int'(rise) + int'(fall);
            end
            chk("en0_pulse", 16'(pulses), 1);
        end
        chk("en0_cnt", cnt, 0);
        en = 1'b1;
        a = ~a;
        repeat (7) tick();
        chk("en1_cnt", cnt, 1);
        // asynchronous reset while a transition is pending
        a = 1'b0;
        do_reset();
        a = 1'b1;
        repeat (4) tick();
        #2;
        rn = 1'b0;
        model_reset();
        #1;
        chk("midpend_y", y, 0);
        check_all();
        tick();
        rn = 1'b1;
        repeat (4) begin
            tick();
            chk("rel_y_low", y, 0);
        end
        tick();
        chk("rel_y", y, 1);
        chk("rel_rise", rise, 1);
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) a = ~a;
            en = ($urandom_range(7) != 0);
            clr = ($urandom_range(31) == 0);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__syncfilt_1.md
Name: gf180mcu_osu_sc_gp12t3v3__syncfilt_1

Overview:
- Clocked receive-side companion to the library's combinational drivers (inv/buf family).
- Takes an asynchronous single-bit level A produced by a driver chain or pad and resynchronizes it to CLK.
- Rejects glitches shorter than a programmable sample count and emits rise/fall pulses.
- Counts accepted transitions, so driver-chain outputs can be characterized on silicon without external logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (legal range 2..4).
- FILT, 3, consecutive post-sync samples required to accept a new level (legal range 1..15; 1 = no filtering).
- CW, 8, width of the transition counter (legal range 2..16).
- RESET_VAL, 0, reset level of the synchronizer chain and of Y.

Ports:
- CLK input 1 rising-edge clock.
- RN input 1 asynchronous active-low reset.
- A input 1 asynchronous data input; no timing relationship to CLK.
- EN input 1 counter enable (synchronous); does not gate the filter.
- CLR input 1 synchronous clear of CNT and OVF.
- Y output 1 filtered, synchronized level (registered).
- RISE output 1 one-cycle pulse on accepted 0->1 transition of Y.
- FALL output 1 one-cycle pulse on accepted 1->0 transition of Y.
- CNT output CW accepted-transition count (registered).
- OVF output 1 sticky flag: a transition was accepted while CNT was saturated.

Behaviour:
- Reset (RN=0, asynchronous, takes effect immediately):
  - All sync flops = RESET_VAL; Y = RESET_VAL.
  - RISE = FALL = 0; CNT = 0; OVF = 0; filter count = 0; state STABLE.
- Release of RN is synchronous to the next CLK edge; no output changes until a rising CLK edge.
- Sync chain: S[0] <= A, S[i] <= S[i-1]. Filter sample s = S[SYNC_STAGES-1].
- Filter FSM, two states; fcnt is ceil(log2(FILT+1)) bits:
  - STABLE: if s == Y, stay, fcnt = 0. If s != Y: fcnt <= 1, go PENDING. When FILT == 1, instead update Y immediately (see accept).
  - PENDING:
    - s == Y: glitch rejected; fcnt <= 0, go STABLE, no pulse.
    - s != Y and fcnt+1 == FILT: accept; Y <= s, fcnt <= 0, go STABLE.
    - Otherwise fcnt <= fcnt+1.
- Accept cycle:
  - Y, RISE/FALL and the CNT update all register on the same edge.
  - RISE = (new Y == 1), FALL = (new Y == 0); pulses last exactly one cycle.
  - RISE and FALL are never both 1.
- Latency: a clean A edge held stable reaches Y after exactly SYNC_STAGES + FILT rising CLK edges (defaults: 5). Minimum accepted pulse width on A is FILT cycles.
- Counter, evaluated on each edge, priority order:
  1. CLR=1: CNT <= 0, OVF <= 0. Overrides a same-cycle accept; the accept still updates Y/RISE/FALL.
  2. Else accept and EN=1 and CNT != all-ones: CNT <= CNT+1.
  3. Else accept and EN=1 and CNT == all-ones: CNT holds (saturates), OVF <= 1.
  4. Else hold.
- EN=0: filter, Y, RISE, FALL still operate; CNT/OVF frozen.
- CNT never wraps; OVF clears only by CLR or RN.
- Reset mid-PENDING: pending transition discarded; after release, Y starts from RESET_VAL and re-qualifies A from scratch.
- A equal to RESET_VAL at release: no pulse, CNT stays 0.

Test Plan:
- Reset/latency: RN low then released, A=0; raise A at cycle 10 and hold -> Y=1 and RISE=1 at cycle 15 (defaults), CNT=1; all outputs 0 during reset.
- Glitch reject: A high for 2 cycles, then low (FILT=3) -> Y stays 0, RISE never asserts, CNT=0. A high for 3 cycles -> accepted, CNT=1, then FALL after the low level qualifies, CNT=2.
- Saturation: CW=2, EN=1, 4 clean transitions -> CNT=3, OVF=1 on the 4th; 5th transition -> CNT=3, OVF=1.
- CLR vs accept: CLR=1 on the same edge as an accepted rise with CNT=2 -> CNT=0, OVF=0, Y=1, RISE=1.
- EN gating: EN=0 across 3 transitions -> RISE/FALL pulse each time, CNT unchanged; re-enable -> next transition increments by 1.
- Async reset mid-PENDING: assert RN while fcnt=2, release -> Y=RESET_VAL and no pulse; holding A=1 gives Y=1 exactly SYNC_STAGES+FILT edges after release.
